// File: rtl/rll_key_loader.sv
// rtl/rll_key_loader.sv - serial key loader with even-parity check feeding an RLL-locked core
module rll_key_loader #(
    parameter int KEY_W = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             zeroize,
    input  logic             ser_data,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);
    localparam int IDX_W = $clog2(KEY_W);

    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, CHECK, LOADED} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [KEY_W-1:0]   shreg, shreg_d, key_d;
    logic               run_par, run_par_d;
    logic               par_ok, par_ok_d;
    logic               key_valid_d, err_d;
    logic               xfer;

    assign ser_ready = (state == SHIFT) || (state == PARITY);
    assign busy      = ser_ready || (state == CHECK);
    assign xfer      = ser_valid && ser_ready;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        shreg_d     = shreg;
        run_par_d   = run_par;
        par_ok_d    = par_ok;
        key_d       = key_out;
        key_valid_d = key_valid;
        err_d       = err;
        if (zeroize) begin
            state_d     = IDLE;
            cnt_d       = '0;
            shreg_d     = '0;
            run_par_d   = 1'b0;
            par_ok_d    = 1'b0;
            key_d       = '0;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state)
                IDLE, LOADED: begin
                    // old key stays on key_out until the new frame resolves
                    if (start) begin
                        state_d   = SHIFT;
                        cnt_d     = '0;
                        shreg_d   = '0;
                        run_par_d = 1'b0;
                        err_d     = 1'b0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        shreg_d[cnt[IDX_W-1:0]] = ser_data;
                        run_par_d = run_par ^ ser_data;
                        if (cnt == CNT_W'(KEY_W - 1))
                            state_d = PARITY;
                        else
                            cnt_d = cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (xfer) begin
                        par_ok_d = (run_par == ser_data);
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    if (par_ok) begin
                        key_d       = shreg;
                        key_valid_d = 1'b1;
                        state_d     = LOADED;
                    end else begin
                        key_d       = '0;
                        key_valid_d = 1'b0;
                        err_d       = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            run_par   <= 1'b0;
            par_ok    <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            shreg     <= shreg_d;
            run_par   <= run_par_d;
            par_ok    <= par_ok_d;
            key_out   <= key_d;
            key_valid <= key_valid_d;
            err       <= err_d;
        end
    end
endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
- Sequential key-delivery block that feeds the 16 key inputs of an RLL-locked combinational netlist.
- Receives the key as a serial bit stream with a valid/ready handshake from the key store or test port, and checks it with an even-parity bit.
- Presents the key in parallel only after the whole frame is received and checks good; otherwise the key outputs are held at zero.
- Sits between the secure key source and the locked core's key pins.

Parameters:
- KEY_W, 16, key width; one bit per locked-core key input.
- CNT_W, 5, bit counter width; must satisfy 2^CNT_W > KEY_W.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a key frame.
- zeroize  input  1  synchronous wipe of key and state.
- ser_data  input  1  serial key/parity bit.
- ser_valid  input  1  ser_data is valid.
- ser_ready  output  1  loader accepts a bit this cycle.
- key_out  output  KEY_W  parallel key; bit i drives locked-core key input i.
- key_valid  output  1  key_out holds a parity-checked key.
- busy  output  1  frame in progress.
- err  output  1  last frame failed parity; sticky until next start or zeroize.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, key_out=0, key_valid=0, busy=0, err=0, ser_ready=0, bit counter=0, shift register=0.
- Transfer occurs on any edge where ser_valid & ser_ready are both 1.
- ser_ready is registered-state-driven: 1 in SHIFT and PARITY, 0 otherwise. No combinational path from ser_valid.
- Frame format: KEY_W data bits, LSB first (first bit lands in key bit 0), followed by one even-parity bit. A frame is good when the XOR of the data bits equals the parity bit.
- States:
  - IDLE: busy=0. If start=1, go to SHIFT; counter=0; err cleared; busy=1 next cycle.
  - SHIFT: each transfer writes ser_data into shift register bit [counter] and increments counter. The transfer with counter=KEY_W-1 moves to PARITY.
  - PARITY: one transfer, compared against the running XOR.
    - Good: next edge key_out <= shift register, key_valid=1, go to LOADED.
    - Bad: next edge key_out=0, key_valid=0, err=1, go to IDLE.
  - LOADED: busy=0; key_out and key_valid held. start=1 goes to SHIFT.
- Reload: the old key_out/key_valid are retained during the new frame. They are replaced on good parity, or cleared on bad parity. The locked core never sees a partial key.
- Latency: key_valid rises on the clk edge after the parity-bit transfer edge. Minimum frame is 1 (start) + 17 transfer cycles.
- ser_valid=0 mid-frame stalls indefinitely with no timeout. Counter and partial data are held.
- start while in SHIFT or PARITY is ignored.
- zeroize=1: at the next edge, same effect as reset except err=0. It has priority over start and over any transfer in that cycle.
- rst_n has priority over zeroize.
- Counter never exceeds KEY_W-1; no wrap beyond the frame.
- A shift register bit not yet written in the current frame is never exposed on key_out.

Test Plan:
- Reset → all outputs 0.
- Good load:
  - Stimulus: start, then 0xA5C3 LSB-first (bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1) with parity 0, ser_valid held 1.
  - Required: ser_ready=1 for 17 cycles; key_out=0xA5C3 and key_valid=1 one edge after the 17th transfer; busy=0 afterwards.
- Parity error:
  - Stimulus: same frame with parity bit 1.
  - Required: key_out=0x0000, key_valid=0, err=1, state IDLE.
  - Then a good frame 0x0001 with parity 1: err clears at start, key_out=0x0001.
- Stall plus reload:
  - Stimulus: from LOADED with 0xA5C3, start a frame for 0x1234 (parity 1) with ser_valid dropped for 5 cycles after bit 7.
  - Required: key_out stays 0xA5C3 throughout and becomes 0x1234 only after parity; no extra bits are accepted during the stall.
- Zeroize mid-frame:
  - Stimulus: assert zeroize at bit 9, with ser_valid=1 that same cycle.
  - Required: next edge key_out=0, key_valid=0, busy=0, ser_ready=0.
  - Then a fresh start and frame 0xFFFF (parity 0) loads correctly.
- Reset priority and ignored start:
  - Stimulus: assert rst_n=0 and zeroize=1 together while in LOADED; separately pulse start during SHIFT.
  - Required: reset values on all outputs; the mid-frame start has no effect on counter or data.
